// File: rtl/wam_game_if.sv
// wam_game_if: event bus from the light and keypad controllers into the game core.
//
// Signals:
//   light_valid   pulse, a new light is lit at light_pos
//   light_pos     lit position
//   light_expire  pulse, the current light has turned off
//   key_valid     pulse, a key press has been decoded
//   key           pressed position
//
// Modports:
//   master  the controllers' side; drives every signal
//   slave   the game core's side; samples every signal
interface wam_game_if #(
    parameter int unsigned POS_W = 4
);
    logic             light_valid;
    logic [POS_W-1:0] light_pos;
    logic             light_expire;
    logic             key_valid;
    logic [POS_W-1:0] key;

    modport master (
        output light_valid,
        output light_pos,
        output light_expire,
        output key_valid,
        output key
    );

    modport slave (
        input light_valid,
        input light_pos,
        input light_expire,
        input key_valid,
        input key
    );
endinterface

// File: rtl/wam_game_core.sv
// wam_game_core: whack-a-mole game sequencer.
//
// Walks IDLE -> LOAD -> READY (countdown) -> PLAY -> OVER and owns the score, misses,
// lights shown, lives and game timer for the points, timed and lives modes.
//
// Ports:
//   CLOCK_50      system clock
//   reset         asynchronous, active-low
//   start         one-cycle start/restart pulse, honoured in every state except LOAD
//   mode          00 points, 01 timed, 10 lives, 11 points; sampled in LOAD
//   target_hits   points-mode light count; sampled in LOAD
//   lives_init    lives-mode starting lives; sampled in LOAD, clamped to 1..MAX_LIVES
//   evt           light/key event bus (slave side)
//   state         IDLE=0, LOAD=1, READY=2, PLAY=3, OVER=4
//   flick_en      high only in PLAY
//   clear_n       low only in LOAD
//   ready_count   seconds remaining in the READY countdown
//   score, misses, lights_shown, time_left, lives_left  game counters
//   game_over     high in OVER
//   streak        consecutive hits; tied to 0 unless the bonus is built in
//
// Build option:
//   WAM_STREAK_BONUS_EN  track the hit streak; a hit that brings the streak to a multiple
//                        of 5 scores 2 instead of 1.
module wam_game_core #(
    parameter int unsigned N_LIGHTS      = 9,
    parameter int unsigned POS_W         = 4,
    parameter int unsigned SCORE_W       = 7,
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned READY_SECS    = 5,
    parameter int unsigned TIME_LIMIT    = 60,
    parameter int unsigned MAX_LIVES     = 9
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [SCORE_W-1:0] target_hits,
    input  logic [3:0]         lives_init,
    wam_game_if.slave          evt,
    output logic [2:0]         state,
    output logic               flick_en,
    output logic               clear_n,
    output logic [3:0]         ready_count,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] misses,
    output logic [SCORE_W-1:0] lights_shown,
    output logic [6:0]         time_left,
    output logic [3:0]         lives_left,
    output logic               game_over,
    output logic [3:0]         streak
);

    localparam int unsigned TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [3:0]        READY_INIT = 4'(READY_SECS);
    localparam logic [6:0]        TIME_INIT  = 7'(TIME_LIMIT);
    localparam logic [3:0]        LIVES_MAX  = 4'(MAX_LIVES);
    localparam logic [1:0]        ModeTimed  = 2'b01;
    localparam logic [1:0]        ModeLives  = 2'b10;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StReady = 3'd2,
        StPlay  = 3'd3,
        StOver  = 3'd4
    } state_e;

    state_e             state_q;
    logic               flick_en_q;
    logic               clear_n_q;
    logic               game_over_q;
    logic [1:0]         mode_q;
    logic [SCORE_W-1:0] target_q;
    logic [POS_W-1:0]   pos_q;
    logic               armed_q;
    logic [TICK_W-1:0]  tick_q;
    logic [3:0]         ready_count_q;
    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W-1:0] misses_q;
    logic [SCORE_W-1:0] shown_q;
    logic [6:0]         time_left_q;
    logic [3:0]         lives_q;
    logic [3:0]         streak_q;

    // Next values for one PLAY cycle.
    logic               hit;
    logic               key_miss;
    logic               exp_miss;
    logic               light_new;
    logic [1:0]         miss_cnt;
    logic [1:0]         score_inc;
    logic               tick_wrap;
    logic [TICK_W-1:0]  tick_nx;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W:0]   miss_sum;
    logic [SCORE_W-1:0] score_nx;
    logic [SCORE_W-1:0] misses_nx;
    logic [SCORE_W-1:0] shown_nx;
    logic               armed_nx;
    logic [POS_W-1:0]   pos_nx;
    logic [3:0]         lives_nx;
    logic [6:0]         time_nx;
    logic [3:0]         streak_nx;
    logic               play_done;
    logic [3:0]         lives_clamped;

    always_comb begin
        lives_clamped = lives_init;
        if (lives_init == 4'd0) begin
            lives_clamped = 4'd1;
        end else if (lives_init > LIVES_MAX) begin
            lives_clamped = LIVES_MAX;
        end
    end

    always_comb begin
        tick_wrap = (tick_q == TICK_LAST);
        tick_nx   = tick_wrap ? '0 : tick_q + TICK_W'(1);

        // The key is judged against the light armed before this cycle; a hit
        // suppresses a same-cycle expire of that light.
        hit       = evt.key_valid && armed_q && (evt.key == pos_q);
        key_miss  = evt.key_valid && !hit;
        exp_miss  = evt.light_expire && armed_q && !hit;
        // Positions off the board are dropped rather than arming an unhittable light.
        light_new = evt.light_valid && (32'(evt.light_pos) < N_LIGHTS);
        miss_cnt  = {1'b0, key_miss} + {1'b0, exp_miss};

`ifdef WAM_STREAK_BONUS_EN
        streak_nx = streak_q;
        score_inc = 2'd1;
        if (hit) begin
            if (streak_q != 4'd15) begin
                streak_nx = streak_q + 4'd1;
                if (streak_nx == 4'd5 || streak_nx == 4'd10 || streak_nx == 4'd15) begin
                    score_inc = 2'd2;
                end
            end
        end else if (key_miss || exp_miss) begin
            streak_nx = 4'd0;
        end
`else
        streak_nx = 4'd0;
        score_inc = 2'd1;
`endif

        score_sum = {1'b0, score_q} + {{(SCORE_W-1){1'b0}}, score_inc};
        score_nx  = score_q;
        if (hit) begin
            score_nx = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        end

        miss_sum  = {1'b0, misses_q} + {{(SCORE_W-1){1'b0}}, miss_cnt};
        misses_nx = miss_sum[SCORE_W] ? '1 : miss_sum[SCORE_W-1:0];

        shown_nx = shown_q;
        if (light_new && shown_q != '1) begin
            shown_nx = shown_q + SCORE_W'(1);
        end

        armed_nx = armed_q;
        pos_nx   = pos_q;
        if (light_new) begin
            armed_nx = 1'b1;
            pos_nx   = evt.light_pos;
        end else if (hit || exp_miss) begin
            armed_nx = 1'b0;
        end

        lives_nx = lives_q;
        if (mode_q == ModeLives) begin
            lives_nx = (lives_q > {2'b00, miss_cnt}) ? lives_q - {2'b00, miss_cnt} : 4'd0;
        end

        time_nx = time_left_q;
        if (mode_q == ModeTimed && tick_wrap && time_left_q != 7'd0) begin
            time_nx = time_left_q - 7'd1;
        end

        if (mode_q == ModeTimed) begin
            play_done = (time_nx == 7'd0);
        end else if (mode_q == ModeLives) begin
            play_done = (lives_nx == 4'd0);
        end else begin
            play_done = (shown_nx == target_q) && !armed_nx;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            flick_en_q    <= 1'b0;
            clear_n_q     <= 1'b1;
            game_over_q   <= 1'b0;
            mode_q        <= 2'b00;
            target_q      <= '0;
            pos_q         <= '0;
            armed_q       <= 1'b0;
            tick_q        <= '0;
            ready_count_q <= READY_INIT;
            score_q       <= '0;
            misses_q      <= '0;
            shown_q       <= '0;
            time_left_q   <= TIME_INIT;
            lives_q       <= 4'd0;
            streak_q      <= 4'd0;
        end else if (start && state_q != StLoad) begin
            // Counters are zeroed on entry so LOAD already shows a fresh game.
            state_q     <= StLoad;
            flick_en_q  <= 1'b0;
            clear_n_q   <= 1'b0;
            game_over_q <= 1'b0;
            score_q     <= '0;
            misses_q    <= '0;
            shown_q     <= '0;
            streak_q    <= 4'd0;
            armed_q     <= 1'b0;
            tick_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                StLoad: begin
                    state_q       <= StReady;
                    clear_n_q     <= 1'b1;
                    mode_q        <= mode;
                    target_q      <= target_hits;
                    lives_q       <= lives_clamped;
                    ready_count_q <= READY_INIT;
                    time_left_q   <= TIME_INIT;
                    tick_q        <= '0;
                    armed_q       <= 1'b0;
                end
                StReady: begin
                    tick_q <= tick_nx;
                    if (tick_wrap) begin
                        ready_count_q <= (ready_count_q > 4'd1) ? ready_count_q - 4'd1 : 4'd0;
                        if (ready_count_q <= 4'd1) begin
                            state_q    <= StPlay;
                            flick_en_q <= 1'b1;
                        end
                    end
                end
                StPlay: begin
                    if (mode_q == ModeTimed) begin
                        tick_q <= tick_nx;
                    end
                    score_q     <= score_nx;
                    misses_q    <= misses_nx;
                    shown_q     <= shown_nx;
                    armed_q     <= armed_nx;
                    pos_q       <= pos_nx;
                    lives_q     <= lives_nx;
                    time_left_q <= time_nx;
                    streak_q    <= streak_nx;
                    if (play_done) begin
                        state_q     <= StOver;
                        flick_en_q  <= 1'b0;
                        game_over_q <= 1'b1;
                    end
                end
                StOver: begin
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign state        = state_q;
    assign flick_en     = flick_en_q;
    assign clear_n      = clear_n_q;
    assign game_over    = game_over_q;
    assign ready_count  = ready_count_q;
    assign score        = score_q;
    assign misses       = misses_q;
    assign lights_shown = shown_q;
    assign time_left    = time_left_q;
    assign lives_left   = lives_q;
    assign streak       = streak_q;

endmodule

// File: tb/tb_wam_game_core.sv
// tb_wam_game_core: scoreboard bench for wam_game_core with a 4-tick second,
// a 3-second countdown and a 2-second timed game.
module tb_wam_game_core;

    localparam int unsigned POS_W   = 4;
    localparam int unsigned SCORE_W = 7;

    logic               CLOCK_50 = 1'b0;
    logic               reset    = 1'b0;
    logic               start    = 1'b0;
    logic [1:0]         mode     = 2'b00;
    logic [SCORE_W-1:0] target_hits = '0;
    logic [3:0]         lives_init  = 4'd0;

    logic [2:0]         state;
    logic               flick_en;
    logic               clear_n;
    logic [3:0]         ready_count;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] misses;
    logic [SCORE_W-1:0] lights_shown;
    logic [6:0]         time_left;
    logic [3:0]         lives_left;
    logic               game_over;
    logic [3:0]         streak;

    wam_game_if #(.POS_W(POS_W)) evt ();

    wam_game_core #(
        .TICKS_PER_SEC(4),
        .READY_SECS   (3),
        .TIME_LIMIT   (2)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .start       (start),
        .mode        (mode),
        .target_hits (target_hits),
        .lives_init  (lives_init),
        .evt         (evt),
        .state       (state),
        .flick_en    (flick_en),
        .clear_n     (clear_n),
        .ready_count (ready_count),
        .score       (score),
        .misses      (misses),
        .lights_shown(lights_shown),
        .time_left   (time_left),
        .lives_left  (lives_left),
        .game_over   (game_over),
        .streak      (streak)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef enum int {
        SelState, SelFlick, SelClearN, SelReady, SelScore, SelMisses,
        SelShown, SelTime, SelLives, SelOver, SelStreak
    } sel_e;

    typedef struct {
        string tag;
        sel_e  sel;
        int    exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic int observe(input sel_e sel);
        case (sel)
            SelState:  return int'(state);
            SelFlick:  return int'(flick_en);
            SelClearN: return int'(clear_n);
            SelReady:  return int'(ready_count);
            SelScore:  return int'(score);
            SelMisses: return int'(misses);
            SelShown:  return int'(lights_shown);
            SelTime:   return int'(time_left);
            SelLives:  return int'(lives_left);
            SelOver:   return int'(game_over);
            default:   return int'(streak);
        endcase
    endfunction

    task automatic expect_val(input string tag, input sel_e sel, input int exp);
        sb_q.push_back('{tag, sel, exp});
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq(e.tag, observe(e.sel), e.exp);
        end
    endtask

    // One clock: inputs driven before the call are sampled at the posedge and
    // outputs are read at the following negedge; pulses are dropped afterwards.
    task automatic cycle();
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        start            = 1'b0;
        evt.light_valid  = 1'b0;
        evt.light_expire = 1'b0;
        evt.key_valid    = 1'b0;
    endtask

    task automatic light(input int pos);
        evt.light_valid = 1'b1;
        evt.light_pos   = POS_W'(pos);
        cycle();
    endtask

    task automatic press(input int k);
        evt.key_valid = 1'b1;
        evt.key       = POS_W'(k);
        cycle();
    endtask

    task automatic expect_play(input string tag, input int st, input int sc, input int mi,
                               input int sh);
        expect_val({tag, "_state"}, SelState, st);
        expect_val({tag, "_score"}, SelScore, sc);
        expect_val({tag, "_misses"}, SelMisses, mi);
        expect_val({tag, "_shown"}, SelShown, sh);
        drain();
    endtask

    task automatic start_game(input int md, input int tgt, input int li, input int exp_lives);
        mode        = 2'(md);
        target_hits = SCORE_W'(tgt);
        lives_init  = 4'(li);
        start       = 1'b1;
        cycle();
        expect_val("load_state", SelState, 1);
        expect_val("load_clear_n", SelClearN, 0);
        expect_val("load_score", SelScore, 0);
        expect_val("load_misses", SelMisses, 0);
        expect_val("load_shown", SelShown, 0);
        expect_val("load_flick", SelFlick, 0);
        drain();
        cycle();
        expect_val("ready_state", SelState, 2);
        expect_val("ready_clear_n", SelClearN, 1);
        expect_val("ready_count0", SelReady, 3);
        expect_val("ready_lives", SelLives, exp_lives);
        expect_val("ready_time", SelTime, 2);
        drain();
        for (int k = 1; k <= 12; k++) begin
            cycle();
            expect_val("ready_count", SelReady, (k < 4) ? 3 : (k < 8) ? 2 : (k < 12) ? 1 : 0);
            expect_val("ready_to_play", SelState, (k < 12) ? 2 : 3);
            drain();
        end
        expect_val("play_flick", SelFlick, 1);
        drain();
    endtask

    initial begin
        evt.light_valid  = 1'b0;
        evt.light_pos    = '0;
        evt.light_expire = 1'b0;
        evt.key_valid    = 1'b0;
        evt.key          = '0;
        repeat (2) @(negedge CLOCK_50);
        expect_val("rst_state", SelState, 0);
        expect_val("rst_ready", SelReady, 3);
        expect_val("rst_time", SelTime, 2);
        expect_val("rst_clear_n", SelClearN, 1);
        expect_val("rst_flick", SelFlick, 0);
        expect_val("rst_over", SelOver, 0);
        expect_val("rst_score", SelScore, 0);
        drain();
        reset = 1'b1;
        cycle();
        expect_val("idle_hold", SelState, 0);
        drain();

        // Points mode, three lights each hit; lives_init 0 clamps to 1.
        start_game(0, 3, 0, 1);
        light(2);
        expect_play("pts_l1", 3, 0, 0, 1);
        press(2);
        expect_play("pts_h1", 3, 1, 0, 1);
        light(5);
        press(5);
        expect_play("pts_h2", 3, 2, 0, 2);
        light(7);
        press(7);
        expect_play("pts_h3", 4, 3, 0, 3);
        expect_val("pts_over", SelOver, 1);
        expect_val("pts_flick_off", SelFlick, 0);
        drain();
        light(4);
        expect_play("pts_frozen", 4, 3, 0, 3);

        // Lives mode with two lives: wrong key then an unhit expire.
        start_game(2, 0, 2, 2);
        light(1);
        press(4);
        expect_play("lives_wrong", 3, 0, 1, 1);
        expect_val("lives_1", SelLives, 1);
        drain();
        evt.light_expire = 1'b1;
        cycle();
        expect_play("lives_expire", 4, 0, 2, 1);
        expect_val("lives_0", SelLives, 0);
        expect_val("lives_over", SelOver, 1);
        drain();

        // Timed mode: two 4-cycle seconds, then light_valid has no effect.
        start_game(1, 0, 3, 3);
        for (int j = 1; j <= 8; j++) begin
            if (j == 1) begin
                evt.light_valid = 1'b1;
                evt.light_pos   = POS_W'(3);
            end
            cycle();
            expect_val("timed_left", SelTime, (j < 4) ? 2 : (j < 8) ? 1 : 0);
            expect_val("timed_state", SelState, (j < 8) ? 3 : 4);
            drain();
        end
        light(6);
        expect_play("timed_frozen", 4, 0, 0, 1);
        expect_val("timed_stop0", SelTime, 0);
        drain();

        // Mode 11 plays as points; same-cycle key/expire and key/new-light.
        start_game(3, 10, 0, 1);
        light(4);
        evt.light_expire = 1'b1;
        press(4);
        expect_play("key_vs_expire", 3, 1, 0, 1);
        light(6);
        evt.light_valid = 1'b1;
        evt.light_pos   = POS_W'(8);
        press(6);
        expect_play("key_vs_new", 3, 2, 0, 3);
        press(6);
        expect_play("old_pos_miss", 3, 2, 1, 3);
        press(8);
        expect_play("new_pos_hit", 3, 3, 1, 3);
        light(0);
        press(0);
        light(1);
        press(1);
        expect_play("score5", 3, 5, 1, 5);

        // Restart mid-play clears the game; lives_init 15 clamps to 9.
        start_game(0, 10, 15, 9);
        for (int i = 0; i < 5; i++) begin
            light(i);
            press(i);
        end
`ifdef WAM_STREAK_BONUS_EN
        expect_play("streak_score", 3, 6, 0, 5);
        expect_val("streak_cnt", SelStreak, 5);
`else
        expect_play("streak_score", 3, 5, 0, 5);
        expect_val("streak_cnt", SelStreak, 0);
`endif
        drain();

        // Asynchronous reset mid-game takes effect without a clock edge.
        #2 reset = 1'b0;
        #1;
        expect_val("arst_state", SelState, 0);
        expect_val("arst_score", SelScore, 0);
        expect_val("arst_ready", SelReady, 3);
        expect_val("arst_time", SelTime, 2);
        expect_val("arst_flick", SelFlick, 0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

endmodule
